// File: rtl/wb_writer.sv
// Write-back stage: holds the MEM-stage result for one cycle, drives the
// register-file write port, and bypasses the value being written to the
// decode-stage read operands. A stalled entry writes exactly once.
module wb_writer (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  input  logic [3:0]  in_dest,
  input  logic [15:0] in_alu_result,
  input  logic [15:0] in_mem_data,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [15:0] rf_data1,
  input  logic [15:0] rf_data2,
  output logic        RegWrite,
  output logic [3:0]  write_register,
  output logic [15:0] write_data,
  output logic [15:0] fwd_data1,
  output logic [15:0] fwd_data2,
  output logic [15:0] wb_count
);

  logic        valid_q;
  logic        reg_write_q;
  logic        mem_to_reg_q;
  logic [3:0]  dest_q;
  logic [15:0] alu_q;
  logic [15:0] mem_q;
  logic        done_q;
  logic [15:0] wb_count_q;

  // Stage register: flush beats stall; a stalled entry remembers it has written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      dest_q       <= 4'd0;
      alu_q        <= 16'd0;
      mem_q        <= 16'd0;
      done_q       <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (!stall) begin
      valid_q      <= in_valid;
      reg_write_q  <= in_reg_write;
      mem_to_reg_q <= in_mem_to_reg;
      dest_q       <= in_dest;
      alu_q        <= in_alu_result;
      mem_q        <= in_mem_data;
      done_q       <= 1'b0;
    end else if (RegWrite) begin
      done_q <= 1'b1;
    end
  end

  // Retired-write counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_count_q <= 16'd0;
    end else if (RegWrite) begin
      wb_count_q <= wb_count_q + 16'd1;
    end
  end

  // Write port and zero-cycle bypass; register 0 is an ordinary register.
  always_comb begin
    RegWrite       = valid_q & reg_write_q & ~done_q;
    write_register = dest_q;
    write_data     = mem_to_reg_q ? mem_q : alu_q;
    fwd_data1      = rf_data1;
    fwd_data2      = rf_data2;
    if (RegWrite && (write_register == rs1)) fwd_data1 = write_data;
    if (RegWrite && (write_register == rs2)) fwd_data2 = write_data;
  end

  assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_writer.sv
// Scoreboard bench for wb_writer: expected writes are queued as entries are
// driven and popped by a monitor whenever the stage asserts RegWrite.
module tb_wb_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [3:0]  in_dest;
  logic [15:0] in_alu_result;
  logic [15:0] in_mem_data;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [15:0] rf_data1;
  logic [15:0] rf_data2;
  logic        RegWrite;
  logic [3:0]  write_register;
  logic [15:0] write_data;
  logic [15:0] fwd_data1;
  logic [15:0] fwd_data2;
  logic [15:0] wb_count;

  typedef struct packed {
    logic [3:0]  dest;
    logic [15:0] data;
  } wr_t;

  wr_t         sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_wb;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  wb_writer dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_reg_write   (in_reg_write),
    .in_mem_to_reg  (in_mem_to_reg),
    .in_dest        (in_dest),
    .in_alu_result  (in_alu_result),
    .in_mem_data    (in_mem_data),
    .rs1            (rs1),
    .rs2            (rs2),
    .rf_data1       (rf_data1),
    .rf_data2       (rf_data2),
    .RegWrite       (RegWrite),
    .write_register (write_register),
    .write_data     (write_data),
    .fwd_data1      (fwd_data1),
    .fwd_data2      (fwd_data2),
    .wb_count       (wb_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one entry for the next posedge; queue the write it must produce.
  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [3:0] dest, input logic [15:0] alu,
                       input logic [15:0] mem);
    in_valid      = v;
    in_reg_write  = rw;
    in_mem_to_reg = m2r;
    in_dest       = dest;
    in_alu_result = alu;
    in_mem_data   = mem;
    if (v && rw && !flush && !stall) begin
      sb_q.push_back({dest, (m2r ? mem : alu)});
      exp_wb = exp_wb + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Every observed write must match the oldest queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (mon_en && reset && RegWrite) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {28'd0, write_register}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("wr_dest", {28'd0, write_register}, {28'd0, e.dest});
        chk("wr_data", {16'd0, write_data}, {16'd0, e.data});
      end
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0;
    in_dest = 4'd0; in_alu_result = 16'd0; in_mem_data = 16'd0;
    rs1 = 4'd1; rs2 = 4'd2; rf_data1 = 16'h1111; rf_data2 = 16'h2222;
    exp_wb = 16'd0;
    mon_en = 1'b1;

    // Reset values
    #12;
    chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_wreg", {28'd0, write_register}, 32'd0);
    chk("rst_wdata", {16'd0, write_data}, 32'd0);
    chk("rst_fwd1", {16'd0, fwd_data1}, 32'h1111);
    chk("rst_fwd2", {16'd0, fwd_data2}, 32'h2222);
    chk("rst_count", {16'd0, wb_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // ALU write to r3
    drive(1'b1, 1'b1, 1'b0, 4'd3, 16'h1234, 16'h0000);
    at_neg();
    chk("alu_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("alu_count_before", {16'd0, wb_count}, 32'd0);
    idle();
    at_neg();
    chk("alu_count_after", {16'd0, wb_count}, 32'd1);

    // Load write to r7 selects memory data
    drive(1'b1, 1'b1, 1'b1, 4'd7, 16'h0004, 16'hBEEF);
    idle();
    at_neg();
    chk("load_count", {16'd0, wb_count}, {16'd0, exp_wb});

    // Bypass
    rs1 = 4'd5; rs2 = 4'd6; rf_data1 = 16'h0001; rf_data2 = 16'h0002;
    drive(1'b1, 1'b1, 1'b0, 4'd5, 16'h00AA, 16'h0000);
    at_neg();
    chk("byp_fwd1", {16'd0, fwd_data1}, 32'h00AA);
    chk("byp_fwd2", {16'd0, fwd_data2}, 32'h0002);
    rs2 = 4'd5; #1;
    chk("byp_both_fwd1", {16'd0, fwd_data1}, 32'h00AA);
    chk("byp_both_fwd2", {16'd0, fwd_data2}, 32'h00AA);
    rs1 = 4'd4; #1;
    chk("byp_miss_fwd1", {16'd0, fwd_data1}, 32'h0001);
    idle();
    at_neg();
    rs1 = 4'd5; #1;
    chk("byp_nowrite_fwd1", {16'd0, fwd_data1}, 32'h0001);

    // Register 0 is writable and bypassable
    rs1 = 4'd0;
    drive(1'b1, 1'b1, 1'b0, 4'd0, 16'hCAFE, 16'h0000);
    at_neg();
    chk("r0_fwd1", {16'd0, fwd_data1}, 32'hCAFE);
    idle();

    // Valid entries without reg_write never write
    drive(1'b1, 1'b0, 1'b0, 4'd8, 16'h5555, 16'h0000);
    at_neg();
    chk("nowr_regwrite", {31'd0, RegWrite}, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 4'd9, 16'h6666, 16'h7777);
    idle();
    at_neg();
    chk("nowr_count", {16'd0, wb_count}, {16'd0, exp_wb});

    // Stall holds a write to r2 for three cycles; it writes only once
    drive(1'b1, 1'b1, 1'b0, 4'd2, 16'h0202, 16'h0000);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 4'd14, 16'hDEAD, 16'h0000);
      at_neg();
      chk("stall_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("stall_wreg", {28'd0, write_register}, 32'd2);
      chk("stall_wdata", {16'd0, write_data}, 32'h0202);
      chk("stall_count", {16'd0, wb_count}, {16'd0, exp_wb});
    end
    in_valid = 1'b0;
    stall = 1'b0;
    idle();
    at_neg();
    chk("stall_release_count", {16'd0, wb_count}, {16'd0, exp_wb});

    // Flush with stall: committing entry finishes, incoming becomes a bubble
    drive(1'b1, 1'b1, 1'b0, 4'd9, 16'h0909, 16'h0000);
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 4'd10, 16'hAAAA, 16'h0000);
    at_neg();
    chk("flush_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("flush_count", {16'd0, wb_count}, {16'd0, exp_wb});
    flush = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'd11, 16'hBBBB, 16'h0000);
    at_neg();
    chk("flush_stall_regwrite", {31'd0, RegWrite}, 32'd0);
    stall = 1'b0;
    idle();
    at_neg();
    chk("flush_after_count", {16'd0, wb_count}, {16'd0, exp_wb});
    chk("sb_empty_mid", sb_q.size(), 32'd0);

    // Restart counting from reset, then preload to 16'hFFFF
    reset = 1'b0; #1;
    chk("rst2_count", {16'd0, wb_count}, 32'd0);
    exp_wb = 16'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 1'b1, i[0], i[3:0], i[15:0], ~i[15:0]);
    end
    idle();
    at_neg();
    chk("preload_count", {16'd0, wb_count}, 32'h0000_FFFF);
    drive(1'b1, 1'b1, 1'b0, 4'd1, 16'h0101, 16'h0000);
    idle();
    at_neg();
    chk("wrap_count", {16'd0, wb_count}, 32'h0000_0000);

    // Reset in the middle of a write cancels it at once
    in_valid = 1'b1; in_reg_write = 1'b1; in_mem_to_reg = 1'b1;
    in_dest = 4'd4; in_alu_result = 16'h0044; in_mem_data = 16'h4444;
    @(posedge clk); #1;
    chk("pre_rst_regwrite", {31'd0, RegWrite}, 32'd1);
    in_valid = 1'b0;
    reset = 1'b0; #1;
    chk("midrst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("midrst_wreg", {28'd0, write_register}, 32'd0);
    chk("midrst_wdata", {16'd0, write_data}, 32'd0);
    chk("midrst_count", {16'd0, wb_count}, 32'd0);
    exp_wb = 16'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 4'd6, 16'h0606, 16'h0000);
    at_neg();
    chk("post_rst_regwrite", {31'd0, RegWrite}, 32'd1);
    idle();
    at_neg();
    chk("post_rst_count", {16'd0, wb_count}, 32'd1);
    chk("sb_empty_end", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
WB_WRITER -- requirements
Module: wb_writer

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold the stage; do not accept new input.
- flush  in  1  replace the incoming entry with a bubble.
- in_valid  in  1  MEM-stage entry valid.
- in_reg_write  in  1  entry writes a register.
- in_mem_to_reg  in  1  1 = write memory data, 0 = write ALU result.
- in_dest  in  4  destination register.
- in_alu_result  in  16  ALU result.
- in_mem_data  in  16  load data.
- rs1  in  4  decode read address 1.
- rs2  in  4  decode read address 2.
- rf_data1  in  16  register-file read data for rs1.
- rf_data2  in  16  register-file read data for rs2.
- RegWrite  out  1  register-file write enable.
- write_register  out  4  register-file write address.
- write_data  out  16  register-file write data.
- fwd_data1  out  16  bypassed operand 1.
- fwd_data2  out  16  bypassed operand 2.
- wb_count  out  16  count of retired register writes.

Function
REQ-002 Stage register fields SHALL be valid_q, reg_write_q, mem_to_reg_q, dest_q[3:0], alu_q[15:0], mem_q[15:0] and done_q.
REQ-003 On a posedge with flush=1, valid_q SHALL load 0 and done_q SHALL load 0; the other fields are don't-care. This applies regardless of stall (flush has priority).
REQ-004 On a posedge with flush=0 and stall=0, all fields SHALL load from the in_* inputs, and done_q SHALL load 0.
REQ-005 On a posedge with flush=0 and stall=1, all fields SHALL hold. done_q SHALL load 1 if RegWrite=1 in that cycle; otherwise done_q holds.
REQ-006 RegWrite SHALL equal valid_q & reg_write_q & ~done_q (combinational), so a held entry writes exactly once.
REQ-007 write_register SHALL equal dest_q.
REQ-008 write_data SHALL equal mem_q when mem_to_reg_q=1, else alu_q.
REQ-009 All 16 registers, including register 0, SHALL be writable; there is no hardwired zero.
REQ-010 fwd_data1 SHALL equal write_data when RegWrite=1 and write_register==rs1, else rf_data1 (combinational, zero-cycle).
REQ-011 fwd_data2 SHALL follow the same rule as REQ-010 using rs2 and rf_data2.
REQ-012 The bypass SHALL apply to both operands at once when rs1==rs2==write_register.
REQ-013 wb_count SHALL increment by 1 on each posedge where RegWrite=1, and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-014 Latency: an entry accepted at posedge N SHALL drive RegWrite during cycle N to N+1, and the register file commits it at posedge N+1.
REQ-015 An entry with in_valid=1 and in_reg_write=0 SHALL never assert RegWrite and SHALL not change wb_count.

Reset
REQ-016 While reset=0, asynchronously: valid_q, reg_write_q, mem_to_reg_q and done_q SHALL be 0; dest_q, alu_q and mem_q SHALL be 0; wb_count SHALL be 0.
REQ-017 Output values during reset SHALL be: RegWrite=0, write_register=0, write_data=0, and fwd_data1/fwd_data2 equal to rf_data1/rf_data2.
REQ-018 Reset asserted mid-write SHALL cancel the write immediately (RegWrite=0 in the same cycle). The first accepted entry after reset deassertion writes normally.

Verification
REQ-019 ALU write: in_valid=1, in_reg_write=1, in_mem_to_reg=0, in_dest=3, in_alu_result=16'h1234 -> next cycle RegWrite=1, write_register=3, write_data=16'h1234; wb_count 0->1.
REQ-020 Load write: in_mem_to_reg=1, in_mem_data=16'hBEEF, in_alu_result=16'h0004, in_dest=7 -> write_data=16'hBEEF, write_register=7.
REQ-021 Bypass: RegWrite=1, write_register=5, write_data=16'h00AA, rs1=5, rs2=6, rf_data1=16'h0001, rf_data2=16'h0002 -> fwd_data1=16'h00AA, fwd_data2=16'h0002.
REQ-022 Stall: accept a write to reg 2, then hold stall=1 for 3 cycles -> RegWrite=1 for exactly one cycle, fields held, wb_count increments once.
REQ-023 Flush with stall: flush=1, stall=1, in_valid=1 -> next cycle RegWrite=0 and wb_count unchanged.
REQ-024 Wrap and reset: preload wb_count to 16'hFFFF via 65535 writes, perform one more write -> wb_count=16'h0000; then drop reset mid-cycle -> RegWrite=0 immediately.
